// File: rtl/operand_fwd_unit.sv
// Operand select and bypass resolution with a two-entry output/skid buffer.
// Operands are resolved in the accept cycle and never re-resolved once captured.
module operand_fwd_unit #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TAG_W   = 6,
  parameter int unsigned NUM_FWD = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [1:0]                i_src1_sel,
  input  logic [1:0]                i_src2_sel,
  input  logic [DATA_W-1:0]         i_rs1,
  input  logic [DATA_W-1:0]         i_rs2,
  input  logic [DATA_W-1:0]         i_imm,
  input  logic [DATA_W-1:0]         i_pc,
  input  logic [TAG_W-1:0]          i_rs1_tag,
  input  logic [TAG_W-1:0]          i_rs2_tag,
  input  logic [NUM_FWD-1:0]        i_fwd_valid,
  input  logic [NUM_FWD*TAG_W-1:0]  i_fwd_tag,
  input  logic [NUM_FWD*DATA_W-1:0] i_fwd_data,
  input  logic                      i_flush,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [DATA_W-1:0]         o_src1,
  output logic [DATA_W-1:0]         o_src2
);

  typedef struct packed {
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
  } opnd_t;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b10
  } state_t;

  state_t      state_q, state_n;
  opnd_t       out_q, out_n;
  opnd_t       skid_q, skid_n;
  logic        valid_q, valid_n;
  logic        ready_q, ready_n;

  logic [DATA_W-1:0] rs1_byp, rs2_byp;
  logic              rs1_hit, rs2_hit;
  opnd_t             req;
  logic              accept, consume;

  // Lowest-index matching channel wins; tag 0 never forwards.
  always_comb begin
    rs1_byp = i_rs1;
    rs2_byp = i_rs2;
    rs1_hit = 1'b0;
    rs2_hit = 1'b0;
    for (int unsigned k = 0; k < NUM_FWD; k++) begin
      if (!rs1_hit && i_fwd_valid[k] && (i_rs1_tag != '0) &&
          (i_fwd_tag[k*TAG_W +: TAG_W] == i_rs1_tag)) begin
        rs1_hit = 1'b1;
        rs1_byp = i_fwd_data[k*DATA_W +: DATA_W];
      end
      if (!rs2_hit && i_fwd_valid[k] && (i_rs2_tag != '0) &&
          (i_fwd_tag[k*TAG_W +: TAG_W] == i_rs2_tag)) begin
        rs2_hit = 1'b1;
        rs2_byp = i_fwd_data[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    req = '0;
    case (i_src1_sel)
      2'b00:   req.src1 = rs1_byp;
      2'b01:   req.src1 = i_pc;
      default: req.src1 = '0;
    endcase
    case (i_src2_sel)
      2'b00:   req.src2 = rs2_byp;
      2'b01:   req.src2 = i_imm;
      2'b10:   req.src2 = DATA_W'(3'd4);
      default: req.src2 = '0;
    endcase
  end

  assign accept  = i_valid && ready_q;
  assign consume = valid_q && i_ready;

  // Next-state and buffer steering; flush overrides accept and consume.
  always_comb begin
    state_n = state_q;
    out_n   = out_q;
    skid_n  = skid_q;
    if (i_flush) begin
      state_n = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_n = ONE;
            out_n   = req;
          end
        end
        ONE: begin
          if (accept && consume) begin
            out_n = req;
          end else if (accept) begin
            state_n = TWO;
            skid_n  = req;
          end else if (consume) begin
            state_n = EMPTY;
          end
        end
        TWO: begin
          if (consume) begin
            state_n = ONE;
            out_n   = skid_q;
          end
        end
        default: state_n = EMPTY;
      endcase
    end
    valid_n = (state_n != EMPTY);
    ready_n = (state_n != TWO);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_n;
      out_q   <= out_n;
      skid_q  <= skid_n;
      valid_q <= valid_n;
      ready_q <= ready_n;
    end
  end

  assign o_valid = valid_q;
  assign o_ready = ready_q;
  assign o_src1  = out_q.src1;
  assign o_src2  = out_q.src2;

endmodule

// File: tb/tb_operand_fwd_unit.sv
// Scoreboard bench for operand_fwd_unit: directed requests push expected operands,
// a negedge monitor pops and compares whenever the DUT delivers an output.
module tb_operand_fwd_unit;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [1:0]  i_src1_sel, i_src2_sel;
  logic [31:0] i_rs1, i_rs2, i_imm, i_pc;
  logic [5:0]  i_rs1_tag, i_rs2_tag;
  logic [1:0]  i_fwd_valid;
  logic [11:0] i_fwd_tag;
  logic [63:0] i_fwd_data;
  logic        i_flush;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_src1, o_src2;

  operand_fwd_unit dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_src1_sel(i_src1_sel), .i_src2_sel(i_src2_sel),
    .i_rs1(i_rs1), .i_rs2(i_rs2), .i_imm(i_imm), .i_pc(i_pc),
    .i_rs1_tag(i_rs1_tag), .i_rs2_tag(i_rs2_tag),
    .i_fwd_valid(i_fwd_valid), .i_fwd_tag(i_fwd_tag), .i_fwd_data(i_fwd_data),
    .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready),
    .o_src1(o_src1), .o_src2(o_src2)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [1:0]  s1, s2;
    logic [31:0] rs1, rs2, imm, pc;
    logic [5:0]  t1, t2;
    logic [1:0]  fv;
    logic [11:0] ftag;
    logic [63:0] fdata;
    logic [31:0] e1, e2;
  } vec_t;

  logic [63:0] exp_q[$];
  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a transfer completes at the next rising edge when both are high.
  always @(negedge i_clk) begin
    if (!i_rst && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_output: got src1=0x%08h src2=0x%08h with nothing expected", o_src1, o_src2);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("out_src1", o_src1, e[63:32]);
        chk("out_src2", o_src2, e[31:0]);
      end
    end
  end

  function automatic vec_t mk(input logic [1:0] s1, input logic [1:0] s2,
                              input logic [31:0] rs1, input logic [31:0] rs2,
                              input logic [31:0] imm, input logic [31:0] pc,
                              input logic [5:0] t1, input logic [5:0] t2,
                              input logic [1:0] fv, input logic [11:0] ftag,
                              input logic [63:0] fdata,
                              input logic [31:0] e1, input logic [31:0] e2);
    vec_t v;
    v.s1 = s1; v.s2 = s2; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.pc = pc;
    v.t1 = t1; v.t2 = t2; v.fv = fv; v.ftag = ftag; v.fdata = fdata;
    v.e1 = e1; v.e2 = e2;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    i_src1_sel = v.s1; i_src2_sel = v.s2;
    i_rs1 = v.rs1; i_rs2 = v.rs2; i_imm = v.imm; i_pc = v.pc;
    i_rs1_tag = v.t1; i_rs2_tag = v.t2;
    i_fwd_valid = v.fv; i_fwd_tag = v.ftag; i_fwd_data = v.fdata;
  endtask

  // Present a request until accepted (bounded); called at posedge+1.
  task automatic issue(input vec_t v);
    bit accepted;
    accepted = 1'b0;
    apply(v);
    i_valid = 1'b1;
    for (int c = 0; c < 20 && !accepted; c++) begin
      if (o_ready) begin
        exp_q.push_back({v.e1, v.e2});
        accepted = 1'b1;
      end
      @(posedge i_clk); #1;
    end
    i_valid = 1'b0;
    i_fwd_valid = 2'b00;
    if (!accepted) begin
      n_vec++;
      n_fail++;
      $display("FAIL accept_timeout: request never accepted, expected acceptance within 20 cycles");
    end
  endtask

  task automatic drain();
    int c;
    c = 0;
    i_ready = 1'b1;
    while (exp_q.size() != 0 && c < 20) begin
      @(posedge i_clk); #1;
      c++;
    end
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  vec_t va, vb, vc, vx;

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
    i_src1_sel = '0; i_src2_sel = '0; i_rs1 = '0; i_rs2 = '0; i_imm = '0; i_pc = '0;
    i_rs1_tag = '0; i_rs2_tag = '0; i_fwd_valid = '0; i_fwd_tag = '0; i_fwd_data = '0;
    #2;
    chk("reset_o_valid", 32'(o_valid), 32'd0);
    chk("reset_o_ready", 32'(o_ready), 32'd1);
    chk("reset_o_src1", o_src1, 32'd0);
    chk("reset_o_src2", o_src2, 32'd0);
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    @(posedge i_clk); #1;

    // PC and CONST4, one-cycle latency
    issue(mk(2'b01, 2'b10, 32'h0, 32'h0, 32'h0, 32'h100, 6'd0, 6'd0, 2'b00, 12'h0, 64'h0,
             32'h100, 32'h4));
    chk("latency_o_valid", 32'(o_valid), 32'd1);
    // two matching channels: lowest index wins
    issue(mk(2'b00, 2'b11, 32'h11, 32'h22, 32'h0, 32'h0, 6'd5, 6'd0, 2'b11,
             {6'd5, 6'd5}, {32'hBB, 32'hAA}, 32'hAA, 32'h0));
    // tag 0 never forwards
    issue(mk(2'b00, 2'b00, 32'h11, 32'h22, 32'h0, 32'h0, 6'd0, 6'd0, 2'b11,
             {6'd0, 6'd0}, {32'hBB, 32'hAA}, 32'h11, 32'h22));
    // only channel 1 matches rs2; invalid channel 0 with matching rs1 tag is ignored
    issue(mk(2'b00, 2'b00, 32'h31, 32'h32, 32'h0, 32'h0, 6'd3, 6'd7, 2'b10,
             {6'd7, 6'd3}, {32'hBB, 32'hCC}, 32'h31, 32'hBB));
    // IMM select ignores a matching forward; src1 sel 10 is zero
    issue(mk(2'b10, 2'b01, 32'h55, 32'h66, 32'h1234, 32'h0, 6'd9, 6'd9, 2'b01,
             {6'd0, 6'd9}, {32'h0, 32'hDEAD}, 32'h0, 32'h1234));
    // src1 sel 11 and src2 sel 11 are zero
    issue(mk(2'b11, 2'b11, 32'h77, 32'h88, 32'h99, 32'h44, 6'd1, 6'd1, 2'b00,
             12'h0, 64'h0, 32'h0, 32'h0));
    drain();

    // Backpressure: A in OUT, B in SKID, C held off
    i_ready = 1'b0;
    va = mk(2'b00, 2'b01, 32'hA1, 32'h0, 32'hA2, 32'h0, 6'd2, 6'd0, 2'b00, 12'h0, 64'h0, 32'hA1, 32'hA2);
    vb = mk(2'b01, 2'b10, 32'h0, 32'h0, 32'h0, 32'hB0, 6'd0, 6'd0, 2'b00, 12'h0, 64'h0, 32'hB0, 32'h4);
    vc = mk(2'b00, 2'b00, 32'hC1, 32'hC2, 32'h0, 32'h0, 6'd4, 6'd0, 2'b01, {6'd0, 6'd4}, {32'h0, 32'hCF}, 32'hCF, 32'hC2);
    issue(va);
    issue(vb);
    chk("two_o_ready", 32'(o_ready), 32'd0);
    apply(vc);
    i_valid = 1'b1;
    repeat (2) begin @(posedge i_clk); #1; end
    chk("stall_o_ready", 32'(o_ready), 32'd0);
    chk("stall_o_valid", 32'(o_valid), 32'd1);
    chk("stall_hold_src1", o_src1, 32'hA1);
    chk("stall_hold_src2", o_src2, 32'hA2);
    i_ready = 1'b1;
    issue(vc);
    drain();

    // Flush in ONE together with an accept: both dropped
    i_ready = 1'b0;
    issue(mk(2'b01, 2'b11, 32'h0, 32'h0, 32'h0, 32'hF1, 6'd0, 6'd0, 2'b00, 12'h0, 64'h0, 32'hF1, 32'h0));
    apply(mk(2'b01, 2'b11, 32'h0, 32'h0, 32'h0, 32'hF2, 6'd0, 6'd0, 2'b00, 12'h0, 64'h0, 32'hF2, 32'h0));
    i_valid = 1'b1; i_flush = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_flush = 1'b0;
    exp_q.delete();
    chk("flush_one_o_valid", 32'(o_valid), 32'd0);
    chk("flush_one_o_ready", 32'(o_ready), 32'd1);

    // Flush in TWO together with a new request
    issue(mk(2'b01, 2'b11, 32'h0, 32'h0, 32'h0, 32'hE1, 6'd0, 6'd0, 2'b00, 12'h0, 64'h0, 32'hE1, 32'h0));
    issue(mk(2'b01, 2'b11, 32'h0, 32'h0, 32'h0, 32'hE2, 6'd0, 6'd0, 2'b00, 12'h0, 64'h0, 32'hE2, 32'h0));
    chk("flush_two_pre_ready", 32'(o_ready), 32'd0);
    apply(mk(2'b01, 2'b11, 32'h0, 32'h0, 32'h0, 32'hE3, 6'd0, 6'd0, 2'b00, 12'h0, 64'h0, 32'hE3, 32'h0));
    i_valid = 1'b1; i_flush = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_flush = 1'b0;
    exp_q.delete();
    chk("flush_two_o_valid", 32'(o_valid), 32'd0);
    chk("flush_two_o_ready", 32'(o_ready), 32'd1);
    i_ready = 1'b1;
    repeat (4) begin @(posedge i_clk); #1; end
    chk("post_flush_o_valid", 32'(o_valid), 32'd0);

    // Asynchronous reset between edges while in ONE
    i_ready = 1'b0;
    vx = mk(2'b01, 2'b10, 32'h0, 32'h0, 32'h0, 32'h5A5A, 6'd0, 6'd0, 2'b00, 12'h0, 64'h0, 32'h5A5A, 32'h4);
    issue(vx);
    #2;
    i_rst = 1'b1;
    #1;
    chk("async_rst_o_valid", 32'(o_valid), 32'd0);
    chk("async_rst_o_ready", 32'(o_ready), 32'd1);
    chk("async_rst_o_src1", o_src1, 32'd0);
    exp_q.delete();
    @(negedge i_clk);
    i_rst = 1'b0;
    i_ready = 1'b1;
    repeat (4) begin @(posedge i_clk); #1; end
    chk("post_rst_o_valid", 32'(o_valid), 32'd0);
    issue(mk(2'b00, 2'b00, 32'h900, 32'h901, 32'h0, 32'h0, 6'd8, 6'd8, 2'b11,
             {6'd8, 6'd1}, {32'h808, 32'h101}, 32'h808, 32'h808));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
